// File: rtl/csa_seq_adder.sv
// ============================================================================
//  Module   : csa_seq_adder
//  Purpose  : Multi-precision add sequencer that reuses one 8-bit carry-skip
//             slice, LSB byte first, with valid/ready operand and result ports.
//             Optional macro CSA_SEQ_SUB_EN adds in_sub (A-B mode).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module csa_seq_adder #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   op_a,
   input  logic [8*NBYTES-1:0]   op_b,
`ifdef CSA_SEQ_SUB_EN
   input  logic                  in_sub,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_sum,
   output logic                  out_carry,
   output logic                  busy
);

   localparam int c_W     = 8 * NBYTES;
   localparam int c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_W-1:0]       r_a;
   logic [c_W-1:0]       r_b;
   logic [c_W-1:0]       r_sum;
   logic [c_IDX_W-1:0]   r_idx;
   logic                 r_carry;
   logic                 r_sub;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;

   logic                 w_sub_in;
   logic [7:0]           w_b_byte;
   logic [4:0]           w_lo;
   logic [4:0]           w_hi;
   logic                 w_p_lo;
   logic                 w_p_hi;
   logic                 w_cin_hi;
   logic                 w_slice_cout;
   logic [7:0]           w_slice_sum;

`ifdef CSA_SEQ_SUB_EN
   assign w_sub_in = in_sub;
`else
   assign w_sub_in = 1'b0;
`endif

   // Subtraction feeds ~B with carry-in 1 (two's complement), so out_carry is an inverted borrow.
   assign w_b_byte = r_b[7:0] ^ {8{r_sub}};

   assign w_p_lo   = &(r_a[3:0] ^ w_b_byte[3:0]);
   assign w_lo     = {1'b0, r_a[3:0]} + {1'b0, w_b_byte[3:0]} + {4'b0000, r_carry};
   assign w_cin_hi = w_p_lo ? r_carry : w_lo[4];
   assign w_p_hi   = &(r_a[7:4] ^ w_b_byte[7:4]);
   assign w_hi     = {1'b0, r_a[7:4]} + {1'b0, w_b_byte[7:4]} + {4'b0000, w_cin_hi};

   assign w_slice_cout = w_p_hi ? w_cin_hi : w_hi[4];
   assign w_slice_sum  = {w_hi[3:0], w_lo[3:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_sub       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= op_a;
                  r_b        <= op_b;
                  r_sub      <= w_sub_in;
                  r_carry    <= w_sub_in;
                  r_idx      <= '0;
                  r_state    <= S_RUN;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_RUN: begin
               for (int i = 0; i < NBYTES; i++) begin
                  if (r_idx == c_IDX_W'(i)) begin
                     r_sum[8*i +: 8] <= w_slice_sum;
                  end
               end
               r_carry <= w_slice_cout;
               r_a     <= r_a >> 8;
               r_b     <= r_b >> 8;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == c_LAST) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_sum   = r_sum;
   assign out_carry = r_carry;
   assign busy      = r_busy;

endmodule

`default_nettype wire
